secure_serdes_crypt_core: RTL and testbench

SECURE_SERDES_CRYPT_CORE -- requirements
Module: secure_serdes_crypt_core

---
 rtl/secure_serdes_crypt_core_if.sv | 37 +++
 rtl/secure_serdes_crypt_core.sv | 117 +++++++++++
 tb/tb_secure_serdes_crypt_core.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/secure_serdes_crypt_core_if.sv
// Bus bundle for secure_serdes_crypt_core: serial plaintext/key in, word and serial ciphertext out.
//
// Handshake: start is a request that is taken only on an edge where busy=0. After
// that the block owns the word. It samples a_bit/b_bit for WIDTH cycles, then
// publishes cipher with cipher_valid=1, then streams ser_out under ser_valid=1
// for WIDTH cycles, and finally pulses done. There is no backpressure. A
// consumer must take ser_out on every cycle in which ser_valid=1. abort (while
// busy) drops the word and clears both valid flags on the next edge.
interface secure_serdes_crypt_core_if #(
  parameter int WIDTH = 8
);
  localparam int RW = $clog2(WIDTH);

  logic             start;
  logic             abort;
  logic             mode;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic [WIDTH-1:0] cipher;
  logic             cipher_valid;
  logic             ser_out;
  logic             ser_valid;
  logic             done;
  logic [2:0]       dbg_state;
  logic [RW-1:0]    dbg_rot;

  modport master (
    output start, abort, mode, a_bit, b_bit,
    input  busy, cipher, cipher_valid, ser_out, ser_valid, done, dbg_state, dbg_rot
  );

  modport slave (
    input  start, abort, mode, a_bit, b_bit,
    output busy, cipher, cipher_valid, ser_out, ser_valid, done, dbg_state, dbg_rot
  );
endinterface

// File: rtl/secure_serdes_crypt_core.sv
// Serial-in / serial-out XOR cipher core with optional rolling (rotated) key.
// The core shifts in one plaintext word and one key word MSB first. It computes
// cipher = A ^ rotl(B, r) in a single cycle, then shifts the result out MSB first.
module secure_serdes_crypt_core #(
  parameter int WIDTH  = 8,
  parameter int ROT_EN = 1
) (
  input logic clk,
  input logic rst,
  secure_serdes_crypt_core_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SHIFT_IN  = 3'd1;
  localparam logic [2:0] S_CRYPT     = 3'd2;
  localparam logic [2:0] S_SHIFT_OUT = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    rot_cnt;
  logic [CW-1:0]    rot_amt;
  logic             mode_q;
  logic             cipher_valid_q;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] cipher_q;
  logic [WIDTH-1:0] out_sh;
  logic [WIDTH-1:0] key_rot;

  // Rotation amount: the rolling counter only applies in rolling mode with rotation enabled.
  always_comb begin
    rot_amt = '0;
    if ((ROT_EN != 0) && mode_q) begin
      rot_amt = rot_cnt;
    end
    // A shift by WIDTH yields zero, so rot_amt=0 degenerates cleanly to b_reg.
    key_rot = (b_reg << rot_amt) | (b_reg >> (WIDTH - int'(rot_amt)));
  end

  // Main sequencer: abort from any busy state wins over everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      rot_cnt        <= '0;
      mode_q         <= 1'b0;
      cipher_valid_q <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      cipher_q       <= '0;
      out_sh         <= '0;
    end else if (bus.abort && (state != S_IDLE)) begin
      // Drop the word; cipher keeps its last value but is no longer marked valid.
      state          <= S_IDLE;
      cnt            <= '0;
      cipher_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state          <= S_SHIFT_IN;
            mode_q         <= bus.mode;
            cnt            <= '0;
            cipher_valid_q <= 1'b0;
          end
        end
        S_SHIFT_IN: begin
          a_reg <= {a_reg[WIDTH-2:0], bus.a_bit};
          b_reg <= {b_reg[WIDTH-2:0], bus.b_bit};
          if (cnt == LAST) begin
            state <= S_CRYPT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CRYPT: begin
          cipher_q       <= a_reg ^ key_rot;
          out_sh         <= a_reg ^ key_rot;
          cipher_valid_q <= 1'b1;
          // The counter advances on every completed word, even in plain mode.
          rot_cnt        <= (rot_cnt == LAST) ? '0 : rot_cnt + 1'b1;
          cnt            <= '0;
          state          <= S_SHIFT_OUT;
        end
        S_SHIFT_OUT: begin
          out_sh <= out_sh << 1;
          if (cnt == LAST) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          // start is deliberately ignored here; a new word begins from IDLE only.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = (state != S_IDLE);
  assign bus.cipher       = cipher_q;
  assign bus.cipher_valid = cipher_valid_q;
  assign bus.ser_valid    = (state == S_SHIFT_OUT);
  assign bus.ser_out      = (state == S_SHIFT_OUT) & out_sh[WIDTH-1];
  assign bus.done         = (state == S_DONE);
  assign bus.dbg_state    = state;
  assign bus.dbg_rot      = rot_cnt;
endmodule

// File: tb/tb_secure_serdes_crypt_core.sv
// Directed bench for secure_serdes_crypt_core (WIDTH=8, ROT_EN=1).
module tb_secure_serdes_crypt_core;
  localparam int W = 8;

  typedef struct {
    bit         rst_first;
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  secure_serdes_crypt_core_if #(.WIDTH(W)) bus ();

  secure_serdes_crypt_core #(.WIDTH(W), .ROT_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mode  = 1'b0;
    bus.a_bit = 1'b0;
    bus.b_bit = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One complete word with checks on timing, cipher, serial stream and done pulse.
  // hold keeps start high through the whole word including the DONE cycle.
  task automatic run_word(input string tag, input logic m, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp, input bit hold);
    logic [7:0] got_ser;
    int nvalid;
    int ndone;
    got_ser = '0;
    nvalid  = 0;
    ndone   = 0;
    bus.start = 1'b1;
    bus.mode  = m;
    tick();  // E0
    chk({tag, " busy_after_e0"}, 32'(bus.busy), 32'd1);
    chk({tag, " cv_cleared_e0"}, 32'(bus.cipher_valid), 32'd0);
    if (!hold) bus.start = 1'b0;
    bus.mode = ~m;  // must not matter: mode was latched on E0
    for (int i = 0; i < W; i++) begin
      bus.a_bit = a[W-1-i];
      bus.b_bit = b[W-1-i];
      tick();  // E1..E8
      ndone += int'(bus.done);
    end
    bus.a_bit = 1'b0;
    bus.b_bit = 1'b0;
    chk({tag, " cv_before_crypt"}, 32'(bus.cipher_valid), 32'd0);
    tick();  // E9
    chk({tag, " cipher"}, 32'(bus.cipher), 32'(exp));
    chk({tag, " cv_after_crypt"}, 32'(bus.cipher_valid), 32'd1);
    for (int k = 0; k < W; k++) begin
      got_ser[W-1-k] = bus.ser_out;
      nvalid += int'(bus.ser_valid);
      ndone  += int'(bus.done);
      tick();  // E10..E17
    end
    chk({tag, " ser_word"}, 32'(got_ser), 32'(exp));
    chk({tag, " ser_valid_cycles"}, 32'(nvalid), 32'd8);
    chk({tag, " no_early_done"}, 32'(ndone), 32'd0);
    chk({tag, " done_after_e17"}, 32'(bus.done), 32'd1);
    chk({tag, " ser_valid_in_done"}, 32'(bus.ser_valid), 32'd0);
    chk({tag, " ser_out_in_done"}, 32'(bus.ser_out), 32'd0);
    tick();
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    chk({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
    chk({tag, " idle_after_done"}, 32'(bus.busy), 32'd0);
    if (hold) begin
      tick();
      chk({tag, " no_extra_word"}, 32'(bus.busy), 32'd0);
    end
  endtask

  vec_t vecs[15];

  initial begin
    int ndone;

    // Vector table: rot_cnt advances once per completed word in any mode.
    vecs[0]  = '{1'b1, 1'b1, 8'h02, 8'h03, 8'h01};  // r=0
    vecs[1]  = '{1'b0, 1'b1, 8'h02, 8'h03, 8'h04};  // r=1, rotl(03,1)=06
    vecs[2]  = '{1'b1, 1'b1, 8'h00, 8'h01, 8'h01};  // wrap run r=0..7,0
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 8'h01, 8'h02};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 8'h01, 8'h04};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h01, 8'h08};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 8'h01, 8'h10};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 8'h01, 8'h20};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'h01, 8'h40};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 8'h01, 8'h80};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 8'h01, 8'h01};  // r wrapped to 0
    vecs[11] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 8'h99};  // plain, rot 1->2
    vecs[12] = '{1'b0, 1'b1, 8'hF0, 8'h81, 8'hF6};  // r=2, rotl(81,2)=06
    vecs[13] = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF};  // r=3
    vecs[14] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00};  // plain

    // Reset state
    do_reset();
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst cipher", 32'(bus.cipher), 32'd0);
    chk("rst cipher_valid", 32'(bus.cipher_valid), 32'd0);
    chk("rst ser_out", 32'(bus.ser_out), 32'd0);
    chk("rst ser_valid", 32'(bus.ser_valid), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst rot", 32'(bus.dbg_rot), 32'd0);
    chk("rst state", 32'(bus.dbg_state), 32'd0);

    // Basic XOR
    run_word("basic_xor", 1'b0, 8'h02, 8'h03, 8'h01, 1'b0);

    // Table-driven rolling-key and wrap vectors (words run back to back)
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].rst_first) do_reset();
      run_word($sformatf("vec%0d", i), vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
    end

    // Abort during SHIFT_IN bit 4
    do_reset();
    run_word("abort_pre", 1'b1, 8'h00, 8'h01, 8'h01, 1'b0);
    bus.start = 1'b1;
    bus.mode  = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.a_bit = 1'b1;
      bus.b_bit = 1'b1;
      tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort state", 32'(bus.dbg_state), 32'd0);
    chk("abort cipher_valid", 32'(bus.cipher_valid), 32'd0);
    chk("abort cipher_held", 32'(bus.cipher), 32'h01);
    chk("abort rot_unchanged", 32'(bus.dbg_rot), 32'd1);
    ndone = int'(bus.done);
    for (int i = 0; i < 3; i++) begin
      tick();
      ndone += int'(bus.done);
    end
    chk("abort no_done", 32'(ndone), 32'd0);
    run_word("abort_post", 1'b1, 8'h00, 8'h01, 8'h02, 1'b0);

    // start held high through a whole word, including the DONE cycle
    run_word("start_held", 1'b0, 8'h5A, 8'h0F, 8'h55, 1'b1);
    run_word("after_held", 1'b0, 8'h3C, 8'hC3, 8'hFF, 1'b0);

    // Asynchronous reset between edges during SHIFT_OUT
    do_reset();
    run_word("arst_pre", 1'b1, 8'h00, 8'h01, 8'h01, 1'b0);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      bus.a_bit = 1'b1;
      bus.b_bit = 1'b0;
      tick();
    end
    bus.a_bit = 1'b0;
    tick();  // E9
    tick();
    tick();
    chk("arst in_shift_out", 32'(bus.ser_valid), 32'd1);
    chk("arst ser_out_high", 32'(bus.ser_out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst busy", 32'(bus.busy), 32'd0);
    chk("arst cipher", 32'(bus.cipher), 32'd0);
    chk("arst cipher_valid", 32'(bus.cipher_valid), 32'd0);
    chk("arst ser_out", 32'(bus.ser_out), 32'd0);
    chk("arst ser_valid", 32'(bus.ser_valid), 32'd0);
    chk("arst done", 32'(bus.done), 32'd0);
    chk("arst rot", 32'(bus.dbg_rot), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("arst idle busy", 32'(bus.busy), 32'd0);
    chk("arst idle ser_valid", 32'(bus.ser_valid), 32'd0);
    chk("arst idle done", 32'(bus.done), 32'd0);
    run_word("arst_post", 1'b1, 8'h00, 8'h01, 8'h01, 1'b0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
